frame_write_arbiter: RTL
========================

Name: frame_write_arbiter

Overview:
- Shares the single pixel-write port of memory_interface between two writers: A = ntsc capture path (raw frame store) and B = projective_transform output.
- Each writer has a small input FIFO and gets a registered "ok to send" flag, with the same semantics as ptflag.
- A burst-limited round-robin FSM drains the FIFOs, converts (x,y) coordinates to linear addresses, and issues writes under memory back-pressure.

Parameters:
- DEPTH, 8, entries per requester FIFO (power of 2, 4..16)
- BURST, 4, maximum consecutive writes granted to one requester while the other is non-empty
- H_PIXELS, 640, line length used in address computation
- BASE_A, 20'd0, address base for requester A
- BASE_B, 20'd307200, address base for requester B
- ADDR_W, 20, memory address width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- a_wr  in  1  requester A write strobe
- a_x  in  10  A pixel x
- a_y  in  9  A pixel y
- a_pixel  in  18  A pixel data
- a_ok  out  1  A may issue a write next cycle
- a_overflow  out  1  sticky: A write dropped
- b_wr  in  1  requester B write strobe (pt_wr)
- b_x  in  10  B pixel x (pt_x)
- b_y  in  9  B pixel y (pt_y)
- b_pixel  in  18  B pixel data (pt_pixel_write)
- b_ok  out  1  B may issue a write next cycle (ptflag)
- b_overflow  out  1  sticky: B write dropped
- clear_overflow  in  1  synchronous clear of both overflow flags
- mem_busy  in  1  memory_interface cannot accept a write this cycle
- mem_wr  out  1  write strobe, one cycle per write
- mem_addr  out  ADDR_W  linear write address
- mem_data  out  18  write data
- grant_b  out  1  current grant owner (0 = A, 1 = B), debug

Behaviour:
- Reset (async, reset_n low):
  - FIFOs emptied; state IDLE; burst counter 0.
  - mem_wr=0, mem_addr=0, mem_data=0, grant_b=0.
  - a_ok=b_ok=1; a_overflow=b_overflow=0.
- Reset asserted mid-operation discards all queued writes; no mem_wr pulse is emitted after reset asserts.
- FIFO push:
  - x_wr high and FIFO not full → push {x,y,pixel} that cycle.
  - x_wr high and FIFO full → entry dropped, x_overflow set.
  - x_overflow holds until clear_overflow; if clear_overflow and a new drop coincide, the flag stays set.
- x_ok is registered: x_ok <= (count_after_this_cycle <= DEPTH-2).
  - This guarantees a requester that registers its strobe from x_ok never overflows.
- Push and pop in the same cycle are legal; count is unchanged. Pop from an empty FIFO never occurs.
- FSM states: IDLE, SERVE_A, SERVE_B.
  - IDLE: if A non-empty → SERVE_A; else if B non-empty → SERVE_B. When both are non-empty, A wins only if the last owner was B (or after reset); otherwise B wins.
  - SERVE_x, when mem_busy low: pop the head, issue the write, increment the burst counter.
  - SERVE_x, when mem_busy high: no pop, mem_wr=0, burst counter frozen.
  - Switch to the other state (burst counter to 0) when x becomes empty after the pop, or when the burst counter reaches BURST and the other FIFO is non-empty.
  - Otherwise stay in SERVE_x (no forced switch when the other FIFO is empty).
  - Both FIFOs empty → IDLE.
- Issue pipeline (registered outputs):
  - mem_wr=1 in the cycle after a pop, with mem_data = popped pixel.
  - mem_addr = BASE_x + y*H_PIXELS + x, computed with shift-add ((y<<9)+(y<<7) for 640), truncated to ADDR_W.
  - mem_wr is otherwise 0.
- Latency: push at cycle t into an empty, idle arbiter with mem_busy low → mem_wr at t+3 (t+1 grant, t+2 pop, t+3 output).
  - Back-to-back pops give one write per cycle while mem_busy stays low.
- mem_busy is sampled at pop time only. A write already registered on the output is committed regardless of mem_busy in its output cycle; memory_interface asserts busy one cycle ahead.
- Coordinates outside the frame (x ≥ H_PIXELS) are passed through unchecked.
- grant_b = 1 in SERVE_B, 0 in SERVE_A, and holds its last value in IDLE.

Test Plan:
- Reset release, single b_wr with x=3, y=2, pixel=18'h2AAAA, mem_busy=0 → one mem_wr three cycles later with addr=307200+1283=308483 and data=18'h2AAAA; a_ok=b_ok=1 throughout.
- Both FIFOs each loaded with 8 entries in one burst, mem_busy=0 → writes alternate in groups A×4, B×4, A×4, B×4; 16 writes total; no overflow.
- b_wr held high for 12 cycles with mem_busy=1 → b_ok drops after 6 entries (registered), 8 entries stored, 4 dropped, b_overflow=1. Deassert busy → exactly 8 writes; clear_overflow → b_overflow=0.
- Requester driven as pt_wr <= b_ok (registered) with mem_busy toggling 1-of-3 cycles for 1000 pixels → no overflow; write count and data order match the input sequence.
- Only A active, 20 back-to-back writes → 20 consecutive mem_wr cycles, no gaps after the initial latency, grant stays A.
- reset_n pulsed low while 5 entries are queued → mem_wr=0 immediately, no writes after release; a_ok=1 and count=0.

Source files
------------

// File: rtl/frame_write_arbiter.sv
// Shares the single pixel-write port between the capture path (A) and the projective
// transform (B): per-writer FIFOs, burst-limited round-robin drain, (x,y) to linear address.

module frame_write_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         clear_overflow,
    output logic [W-1:0] head,
    output logic         not_empty,
    output logic         draining,
    output logic         ok,
    output logic         overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          push;

    assign full      = (count == CW'(DEPTH));
    assign push      = wr && !full;
    assign not_empty = (count != '0);
    // a pop this cycle leaves the FIFO empty only if nothing is being pushed alongside it
    assign draining  = (count == CW'(1)) && !push;
    assign head      = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ok       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            ok    <= (count_next <= CW'(DEPTH - 2));
            if (wr && full)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end
endmodule

module frame_write_arbiter #(
    parameter int                DEPTH    = 8,
    parameter int                BURST    = 4,
    parameter int                H_PIXELS = 640,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] BASE_A   = 20'd0,
    parameter logic [ADDR_W-1:0] BASE_B   = 20'd307200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_wr,
    input  logic [9:0]        a_x,
    input  logic [8:0]        a_y,
    input  logic [17:0]       a_pixel,
    output logic              a_ok,
    output logic              a_overflow,
    input  logic              b_wr,
    input  logic [9:0]        b_x,
    input  logic [8:0]        b_y,
    input  logic [17:0]       b_pixel,
    output logic              b_ok,
    output logic              b_overflow,
    input  logic              clear_overflow,
    input  logic              mem_busy,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [17:0]       mem_data,
    output logic              grant_b
);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_A = 2'd1, SERVE_B = 2'd2} state_t;

    state_t            state;
    state_t            state_next;
    logic [BW-1:0]     burst_cnt;
    logic [BW-1:0]     burst_next;
    logic [BW-1:0]     burst_inc;
    logic              prefer_a;
    logic [36:0]       head_a;
    logic [36:0]       head_b;
    logic [36:0]       sel;
    logic              a_ne, b_ne, a_drain, b_drain;
    logic              pop_a, pop_b;
    logic [ADDR_W-1:0] addr_next;

    frame_write_fifo #(.DEPTH(DEPTH), .W(37)) u_fifo_a (
        .clk(clk), .reset_n(reset_n), .wr(a_wr), .din({a_x, a_y, a_pixel}), .pop(pop_a),
        .clear_overflow(clear_overflow), .head(head_a), .not_empty(a_ne),
        .draining(a_drain), .ok(a_ok), .overflow(a_overflow)
    );

    frame_write_fifo #(.DEPTH(DEPTH), .W(37)) u_fifo_b (
        .clk(clk), .reset_n(reset_n), .wr(b_wr), .din({b_x, b_y, b_pixel}), .pop(pop_b),
        .clear_overflow(clear_overflow), .head(head_b), .not_empty(b_ne),
        .draining(b_drain), .ok(b_ok), .overflow(b_overflow)
    );

    assign pop_a = (state == SERVE_A) && a_ne && !mem_busy;
    assign pop_b = (state == SERVE_B) && b_ne && !mem_busy;

    // y*640 as (y<<9)+(y<<7); other line lengths fall back to a multiply
    function automatic logic [ADDR_W-1:0] line_offset(input logic [8:0] y);
        if (H_PIXELS == 640)
            return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7);
        else
            return ADDR_W'(y) * ADDR_W'(H_PIXELS);
    endfunction

    assign sel       = pop_b ? head_b : head_a;
    assign addr_next = (pop_b ? BASE_B : BASE_A) + line_offset(sel[26:18]) + ADDR_W'(sel[36:27]);

    always_comb begin
        state_next = state;
        burst_next = burst_cnt;
        burst_inc  = (burst_cnt == BW'(BURST)) ? burst_cnt : burst_cnt + 1'b1;
        case (state)
            IDLE: begin
                burst_next = '0;
                if (a_ne && (!b_ne || prefer_a))
                    state_next = SERVE_A;
                else if (b_ne)
                    state_next = SERVE_B;
            end
            SERVE_A: begin
                if (!a_ne) begin
                    burst_next = '0;
                    state_next = b_ne ? SERVE_B : IDLE;
                end else if (pop_a) begin
                    burst_next = burst_inc;
                    if (a_drain || ((burst_inc == BW'(BURST)) && b_ne)) begin
                        burst_next = '0;
                        state_next = b_ne ? SERVE_B : IDLE;
                    end
                end
            end
            SERVE_B: begin
                if (!b_ne) begin
                    burst_next = '0;
                    state_next = a_ne ? SERVE_A : IDLE;
                end else if (pop_b) begin
                    burst_next = burst_inc;
                    if (b_drain || ((burst_inc == BW'(BURST)) && a_ne)) begin
                        burst_next = '0;
                        state_next = a_ne ? SERVE_A : IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                burst_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            prefer_a  <= 1'b1;
            grant_b   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_next;
            if (state_next == SERVE_A) begin
                grant_b  <= 1'b0;
                prefer_a <= 1'b0;
            end else if (state_next == SERVE_B) begin
                grant_b  <= 1'b1;
                prefer_a <= 1'b1;
            end
            mem_wr <= pop_a || pop_b;
            if (pop_a || pop_b) begin
                mem_addr <= addr_next;
                mem_data <= sel[17:0];
            end
        end
    end
endmodule
